mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of per-requester grant counters.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid/req1_valid  input  1  requester has operands pending.
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  4  requester operands.
REQ-006 SHALL have ports: req0_ready/req1_ready  output  1  arbiter accepts that requester this cycle.
REQ-007 SHALL have ports: mul_a, mul_b  output  4  operands to the shared 4-bit combinational multiplier.
REQ-008 SHALL have ports: mul_p_low, mul_p_high  input  4  low/high product nibbles from the multiplier.
REQ-009 SHALL have ports: rsp_valid  output  1; rsp_id  output  1 (granted requester); rsp_product  output  8  {high,low}.
REQ-010 SHALL have port: rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have ports: gnt_cnt0/gnt_cnt1  output  CNT_W  accepted transactions per requester.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-013 SHALL assert reqN_ready only in IDLE, only for the requester selected by arbitration; at most one ready high per cycle.
REQ-014 SHALL, in IDLE with exactly one valid requester, select it; with both valid, select the requester not equal to last_gnt (round robin).
REQ-015 SHALL, on accept (valid & ready), latch operands into mul_a/mul_b, latch rsp_id, update last_gnt, go to ISSUE.
REQ-016 SHALL hold mul_a/mul_b stable from ISSUE through RESP until the next accept.
REQ-017 SHALL, at end of ISSUE, register {mul_p_high, mul_p_low} into rsp_product and go to RESP.
REQ-018 SHALL assert rsp_valid exactly in RESP; rsp_valid first high 2 cycles after the accept edge.
REQ-019 SHALL hold rsp_valid, rsp_id, rsp_product stable while rsp_valid & !rsp_ready.
REQ-020 SHALL return to IDLE on rsp_valid & rsp_ready; next accept no earlier than the following cycle (max 1 transaction per 3 cycles).
REQ-021 SHALL increment gnt_cntN on each accept of requester N, saturating at all-ones (no wrap).
REQ-022 SHALL ignore reqN_a/b changes outside the accept cycle; a requester dropping valid before accept is never granted.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, last_gnt=1, rsp_valid=0, rsp_id=0, rsp_product=0, mul_a=mul_b=0, gnt_cnt0=gnt_cnt1=0, both ready low while in reset.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation; no response is produced for it after reset release.
REQ-025 SHALL allow accept on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with MUL_ARB_FIXED_PRI_EN defined, grant req0 whenever req0_valid in IDLE (fixed priority; last_gnt still tracked but unused).
REQ-027 SHALL, without MUL_ARB_FIXED_PRI_EN, use round robin per REQ-014.

Verification
REQ-028 SHALL cover: req0 a=2,b=3 alone, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_product=0x06, gnt_cnt0=1.
REQ-029 SHALL cover: both valid after reset, req0 5*5, req1 15*15 -> first rsp id0 0x19, second rsp id1 0xE1 (high 1110, low 0001); with MUL_ARB_FIXED_PRI_EN and req0 held valid, req1 starved.
REQ-030 SHALL cover: req1 9*4 with rsp_ready low 5 cycles -> rsp_valid held, rsp_product=0x24 stable, both ready low throughout.
REQ-031 SHALL cover: rst_n pulsed low during RESP of 6*3 -> rsp_valid drops immediately, no 0x12 response after release, counters zero.
REQ-032 SHALL cover: CNT_W=2, 5 req0 accepts -> gnt_cnt0 saturates at 3.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester, shared-multiplier and response signals of mul_arbiter
interface mul_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req0_ready;
    logic       req1_ready;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [3:0] mul_p_low;
    logic [3:0] mul_p_high;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_product;
    logic       rsp_ready;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  mul_p_low, mul_p_high, rsp_ready,
        output req0_ready, req1_ready, mul_a, mul_b,
        output rsp_valid, rsp_id, rsp_product
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output mul_p_low, mul_p_high, rsp_ready,
        input  req0_ready, req1_ready, mul_a, mul_b,
        input  rsp_valid, rsp_id, rsp_product
    );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester arbiter for a shared 4x4 multiplier (option: MUL_ARB_FIXED_PRI_EN)
module mul_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic             rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_product_q, rsp_product_d;
    logic [3:0]       mul_a_q, mul_a_d;
    logic [3:0]       mul_b_q, mul_b_d;
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

    logic sel0, sel1;
    logic acc0, acc1;

    // Arbitration: pick at most one valid requester; the other only wins when req0 does not
    always_comb begin
`ifdef MUL_ARB_FIXED_PRI_EN
        sel0 = bus.req0_valid;
`else
        sel0 = bus.req0_valid && (!bus.req1_valid || last_gnt_q);
`endif
        sel1 = bus.req1_valid && !sel0;
    end

    // Output decode: ready only in IDLE and never while reset is asserted
    always_comb begin
        acc0 = rst_n && (state_q == IDLE) && sel0;
        acc1 = rst_n && (state_q == IDLE) && sel1;
    end

    assign bus.req0_ready  = acc0;
    assign bus.req1_ready  = acc1;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign gnt_cnt0        = gnt_cnt0_q;
    assign gnt_cnt1        = gnt_cnt1_q;

    // Next-state: one issue cycle for the multiplier, then hold the response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc0 || acc1) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, capture the product at the end of ISSUE
    always_comb begin
        last_gnt_d    = last_gnt_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        gnt_cnt0_d    = gnt_cnt0_q;
        gnt_cnt1_d    = gnt_cnt1_q;
        if (acc0) begin
            mul_a_d    = bus.req0_a;
            mul_b_d    = bus.req0_b;
            rsp_id_d   = 1'b0;
            last_gnt_d = 1'b0;
            if (gnt_cnt0_q != {CNT_W{1'b1}}) gnt_cnt0_d = gnt_cnt0_q + 1'b1;
        end
        if (acc1) begin
            mul_a_d    = bus.req1_a;
            mul_b_d    = bus.req1_b;
            rsp_id_d   = 1'b1;
            last_gnt_d = 1'b1;
            if (gnt_cnt1_q != {CNT_W{1'b1}}) gnt_cnt1_d = gnt_cnt1_q + 1'b1;
        end
        if (state_q == ISSUE) rsp_product_d = {bus.mul_p_high, bus.mul_p_low};
    end

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_gnt_q    <= 1'b1;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= 8'h00;
            mul_a_q       <= 4'h0;
            mul_b_q       <= 4'h0;
            gnt_cnt0_q    <= '0;
            gnt_cnt1_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            gnt_cnt0_q    <= gnt_cnt0_d;
            gnt_cnt1_q    <= gnt_cnt1_d;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter
module tb_mul_arbiter;
    logic       clk;
    logic       rst_n;
    logic [7:0] gnt_cnt0, gnt_cnt1;
    logic [1:0] s_cnt0, s_cnt1;
    logic [7:0] prod_m, s_prod_m;
    int         n_checks;
    int         n_pass;
    int         seen;

    mul_arbiter_if bus ();
    mul_arbiter_if sbus ();

    mul_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    mul_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(sbus), .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
    );

    assign prod_m          = bus.mul_a * bus.mul_b;
    assign bus.mul_p_low   = prod_m[3:0];
    assign bus.mul_p_high  = prod_m[7:4];
    assign s_prod_m        = sbus.mul_a * sbus.mul_b;
    assign sbus.mul_p_low  = s_prod_m[3:0];
    assign sbus.mul_p_high = s_prod_m[7:4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
        bus.rsp_ready  = 1'b1;
        sbus.req0_valid = 1'b1; sbus.req1_valid = 1'b0;
        sbus.req0_a = 4'h1; sbus.req0_b = 4'h1; sbus.req1_a = 4'h0; sbus.req1_b = 4'h0;
        sbus.rsp_ready  = 1'b1;

        // reset state, with a requester already valid
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd3;
        #1;
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_product", bus.rsp_product, 8'h00);
        check("rst_mul", {bus.mul_a, bus.mul_b}, 8'h00);
        check("rst_cnt", {gnt_cnt0, gnt_cnt1}, 16'h0000);

        // 2*3 from req0, accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req0_a = 4'd7;
        #1;
        check("t1_issue_valid", bus.rsp_valid, 1'b0);
        check("t1_mul", {bus.mul_a, bus.mul_b}, {4'd2, 4'd3});
        check("t1_cnt0", gnt_cnt0, 8'd1);
        @(negedge clk);
        check("t1_rsp_valid", bus.rsp_valid, 1'b1);
        check("t1_rsp_id", bus.rsp_id, 1'b0);
        check("t1_product", bus.rsp_product, 8'h06);
        @(negedge clk);
        check("t1_idle", bus.rsp_valid, 1'b0);

        // both valid after reset: req0 5*5 then the other arbitration outcome
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd5;  bus.req0_b = 4'd5;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd15; bus.req1_b = 4'd15;
        #1;
        check("t2_first_sel", {bus.req0_ready, bus.req1_ready}, 2'b10);
        repeat (2) @(negedge clk);
        check("t2_rsp0_valid", bus.rsp_valid, 1'b1);
        check("t2_rsp0_id", bus.rsp_id, 1'b0);
        check("t2_rsp0_product", bus.rsp_product, 8'h19);
        @(negedge clk);
`ifdef MUL_ARB_FIXED_PRI_EN
        check("t2_second_sel", {bus.req0_ready, bus.req1_ready}, 2'b10);
        repeat (2) @(negedge clk);
        check("t2_rsp1_id", bus.rsp_id, 1'b0);
        check("t2_rsp1_product", bus.rsp_product, 8'h19);
`else
        check("t2_second_sel", {bus.req0_ready, bus.req1_ready}, 2'b01);
        repeat (2) @(negedge clk);
        check("t2_rsp1_id", bus.rsp_id, 1'b1);
        check("t2_rsp1_product", bus.rsp_product, 8'hE1);
`endif
        check("t2_cnt0", gnt_cnt0, 8'd1 + (gnt_cnt1 == 8'd0 ? 8'd1 : 8'd0));

        // req1 9*4 with the consumer stalled for 5 cycles
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_a = 4'd9; bus.req1_b = 4'd4;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        bus.req1_valid = 1'b0; bus.req1_a = 4'd1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", bus.rsp_valid, 1'b1);
            check("t3_hold_product", bus.rsp_product, 8'h24);
            check("t3_hold_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
            @(negedge clk);
        end
        check("t3_rsp_id", bus.rsp_id, 1'b1);
        check("t3_mul_hold", {bus.mul_a, bus.mul_b}, {4'd9, 4'd4});
        check("t3_cnt1", gnt_cnt1, 8'd1);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        check("t3_release", bus.rsp_valid, 1'b0);

        // reset pulse in RESP of 6*3
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd6; bus.req0_b = 4'd3;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t4_pre_valid", bus.rsp_valid, 1'b1);
        check("t4_pre_product", bus.rsp_product, 8'h12);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_valid", bus.rsp_valid, 1'b0);
        check("t4_rst_product", bus.rsp_product, 8'h00);
        check("t4_rst_cnt", {gnt_cnt0, gnt_cnt1}, 16'h0000);
        check("t4_rst_mul", {bus.mul_a, bus.mul_b}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("t4_no_stale_rsp", seen, 0);
        check("t4_cnt_after", {gnt_cnt0, gnt_cnt1}, 16'h0000);

        // CNT_W=2 instance, req0 always valid since the last reset release
        check("t5_cnt_two", s_cnt0, 2'd2);
        repeat (12) @(negedge clk);
        check("t5_cnt_sat", s_cnt0, 2'd3);
        check("t5_cnt1_idle", s_cnt1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
